uncache_bus_arbiter: RTL
========================

Name: uncache_bus_arbiter

Overview:
- Shares the single simple-bus port of the AXI bridge (axi_en/axi_wsel/axi_addr/axi_wdata out; reload/axi_rdata in) between two uncached requesters: the instruction-side and the data-side uncache.
- Arbitration is fixed priority, data over inst, with a starvation guard for inst.
- Adds a bridge watchdog so a hung transaction cannot stall the pipeline forever.
- Sits between the two uncache instances and the AXI bridge.

Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants made while inst_en is pending, after which inst wins the next arbitration.
- TIMEOUT, 255: maximum cycles in BUSY without reload before the watchdog fires. 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state updates on posedge
- resetn  in  1  asynchronous active-low reset
- inst_en  in  1  inst request; held with inst_wsel/inst_addr/inst_wdata stable until inst_reload
- inst_wsel  in  4  byte write strobes; 0 means read
- inst_addr  in  32  request address
- inst_wdata  in  32  write data
- inst_reload  out  1  one-cycle completion pulse to inst
- inst_rdata  out  32  read data, valid while inst_reload=1
- data_en, data_wsel, data_addr, data_wdata  in  1/4/32/32  same semantics, data side
- data_reload  out  1  one-cycle completion pulse to data
- data_rdata  out  32  read data, valid while data_reload=1
- axi_en  out  1  request to bridge, registered
- axi_wsel  out  4  registered strobes to bridge
- axi_addr  out  32  registered address to bridge
- axi_wdata  out  32  registered write data to bridge
- reload  in  1  bridge completion pulse
- axi_rdata  in  32  bridge read data, valid with reload
- owner  out  1  current/last grant: 0 = inst, 1 = data (registered)
- bus_err  out  1  sticky: watchdog fired; cleared only by reset

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; axi_en=0, axi_wsel=0, axi_addr=0, axi_wdata=0.
  - owner=0, bus_err=0, starve_cnt=0, wd_cnt=0.
  - A reset mid-transaction abandons the transaction; no reload is forwarded.
- States: IDLE, BUSY, TURN, DRAIN.
- IDLE:
  - Choose a winner:
    - if only one of inst_en/data_en is high, that requester wins.
    - if both are high, data wins unless starve_cnt==STARVE_LIMIT, in which case inst wins.
  - On the edge: latch the winner's wsel/addr/wdata into axi_*, set axi_en=1, set owner, go to BUSY, wd_cnt=0.
  - Grant latency: request seen in cycle N, axi_en=1 in cycle N+1.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when data is granted while inst_en=1.
  - Clears to 0 when inst is granted.
  - Holds otherwise.
- BUSY:
  - axi_* held constant.
  - inst_reload = reload & (owner==0); data_reload = reload & (owner==1). Both are combinational, in the same cycle as reload.
  - On a reload edge: axi_en=0 and axi_wsel/axi_addr/axi_wdata=0; go to TURN.
  - Without reload: wd_cnt increments.
  - If TIMEOUT!=0 and wd_cnt==TIMEOUT-1 with reload=0 (watchdog):
    - pulse the owner's *_reload for this cycle with its *_rdata forced to 32'h0;
    - bus_err<=1; axi_en<=0; go to DRAIN.
- TURN:
  - One dead cycle with no grant, so the completed requester can drop en.
  - Always go to IDLE.
- DRAIN:
  - Wait for the bridge's late reload; it is discarded and forwarded to nobody.
  - On reload, go to IDLE. No grants are made while in DRAIN.
- inst_rdata/data_rdata: equal axi_rdata at all times, except forced to 0 on a watchdog pulse.
- reload in IDLE or TURN: ignored, no forwarding.
- Simultaneous events:
  - A request arriving in the reload cycle waits until IDLE; earliest axi_en is 3 cycles after reload.
  - en deasserted before grant: the request is withdrawn, no error.
- Back-to-back throughput: one transaction per bridge latency + 3 cycles.

Test Plan:
- Single read: data_en=1, data_wsel=0, data_addr=32'h1faf_f000; bridge returns reload with axi_rdata=32'h1234_5678 after 5 cycles.
  -> axi_en rises 1 cycle after request with axi_addr=32'h1faf_f000; data_reload=1 for exactly 1 cycle with data_rdata=32'h1234_5678; inst_reload stays 0; axi_en=0 the next cycle.
- Simultaneous requests: inst_addr=32'hbfc0_0000 and data_addr=32'h1faf_fff0 (data_wsel=4'hf, wdata=32'hAA) raised in the same cycle.
  -> data is granted first with axi_wsel=4'hf; inst is granted 3 cycles after the data reload; owner goes 1 then 0.
- Starvation: data_en held continuously, inst_en held, STARVE_LIMIT=4.
  -> exactly 4 data grants, then an inst grant, then starve_cnt=0.
- Watchdog: TIMEOUT=8, bridge never reloads for a data read.
  -> on the 8th BUSY cycle, data_reload=1 with data_rdata=0, bus_err=1, axi_en=0; state stays DRAIN with no new grant until the bridge reload, which is not forwarded.
- Reset mid-transaction: resetn=0 while BUSY with axi_en=1.
  -> axi_en and all axi_* are 0 immediately (asynchronous); no *_reload pulse; after release the next request is granted normally.
- Stray reload in IDLE: reload=1 with no owner.
  -> inst_reload=data_reload=0; state remains IDLE.

Source files
------------

// File: rtl/uncache_bus_arbiter.sv
// Shares the AXI bridge simple-bus port between the inst-side and data-side uncache.
// Fixed priority data-over-inst with an inst starvation guard, plus a bridge watchdog.
//
// state | meaning
// IDLE  | no transaction; arbitrate and grant on the clock edge
// BUSY  | request presented to bridge, waiting for reload
// TURN  | dead cycle after completion so the requester can drop en
// DRAIN | watchdog fired; swallow the bridge's late reload
module uncache_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_en,
  input  logic [3:0]  inst_wsel,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_reload,
  output logic [31:0] inst_rdata,
  input  logic        data_en,
  input  logic [3:0]  data_wsel,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_reload,
  output logic [31:0] data_rdata,
  output logic        axi_en,
  output logic [3:0]  axi_wsel,
  output logic [31:0] axi_addr,
  output logic [31:0] axi_wdata,
  input  logic        reload,
  input  logic [31:0] axi_rdata,
  output logic        owner,
  output logic        bus_err
);

  localparam int unsigned SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SC_W-1:0] SC_LIMIT = SC_W'(STARVE_LIMIT);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam bit              WD_ON    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_TURN  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              axi_en_q, axi_en_d;
  logic [3:0]        axi_wsel_q, axi_wsel_d;
  logic [31:0]       axi_addr_q, axi_addr_d;
  logic [31:0]       axi_wdata_q, axi_wdata_d;
  logic              owner_q, owner_d;
  logic              bus_err_q, bus_err_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              wd_fire;
  logic              grant_data;

  always_comb begin
    state_d     = state_q;
    axi_en_d    = axi_en_q;
    axi_wsel_d  = axi_wsel_q;
    axi_addr_d  = axi_addr_q;
    axi_wdata_d = axi_wdata_q;
    owner_d     = owner_q;
    bus_err_d   = bus_err_q;
    starve_d    = starve_q;
    wd_d        = wd_q;
    wd_fire     = 1'b0;
    grant_data  = 1'b0;
    inst_reload = 1'b0;
    data_reload = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (inst_en | data_en) begin
          // inst only overrides data once it has watched STARVE_LIMIT data grants go by
          grant_data  = data_en & ~(inst_en & (starve_q == SC_LIMIT));
          state_d     = S_BUSY;
          axi_en_d    = 1'b1;
          axi_wsel_d  = grant_data ? data_wsel  : inst_wsel;
          axi_addr_d  = grant_data ? data_addr  : inst_addr;
          axi_wdata_d = grant_data ? data_wdata : inst_wdata;
          owner_d     = grant_data;
          wd_d        = '0;
          if (!grant_data) begin
            starve_d = '0;
          end else if (inst_en && (starve_q != SC_LIMIT)) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end

      S_BUSY: begin
        inst_reload = reload & ~owner_q;
        data_reload = reload & owner_q;
        if (reload) begin
          state_d     = S_TURN;
          axi_en_d    = 1'b0;
          axi_wsel_d  = '0;
          axi_addr_d  = '0;
          axi_wdata_d = '0;
        end else if (WD_ON && (wd_q == WD_LAST)) begin
          wd_fire     = 1'b1;
          inst_reload = ~owner_q;
          data_reload = owner_q;
          bus_err_d   = 1'b1;
          state_d     = S_DRAIN;
          axi_en_d    = 1'b0;
          axi_wsel_d  = '0;
          axi_addr_d  = '0;
          axi_wdata_d = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_TURN: begin
        state_d = S_IDLE;
      end

      S_DRAIN: begin
        if (reload) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      axi_en_q    <= 1'b0;
      axi_wsel_q  <= '0;
      axi_addr_q  <= '0;
      axi_wdata_q <= '0;
      owner_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      starve_q    <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      axi_en_q    <= axi_en_d;
      axi_wsel_q  <= axi_wsel_d;
      axi_addr_q  <= axi_addr_d;
      axi_wdata_q <= axi_wdata_d;
      owner_q     <= owner_d;
      bus_err_q   <= bus_err_d;
      starve_q    <= starve_d;
      wd_q        <= wd_d;
    end
  end

  // a watchdog completion returns zero data rather than whatever the bridge last drove
  assign inst_rdata = wd_fire ? 32'h0 : axi_rdata;
  assign data_rdata = wd_fire ? 32'h0 : axi_rdata;

  assign axi_en    = axi_en_q;
  assign axi_wsel  = axi_wsel_q;
  assign axi_addr  = axi_addr_q;
  assign axi_wdata = axi_wdata_q;
  assign owner     = owner_q;
  assign bus_err   = bus_err_q;

endmodule
